// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue controller: opcodes, flag bit
// positions, instruction field slices and the issue FSM state encoding.
package alu_pkg;

   localparam logic [7:0] OP_ADD     = 8'h00;
   localparam logic [7:0] OP_SUB     = 8'h01;
   localparam logic [7:0] OP_MUL     = 8'h02;
   localparam logic [7:0] OP_EQ      = 8'h03;
   localparam logic [7:0] OP_GT      = 8'h04;
   localparam logic [7:0] OP_ADD_IMM = 8'h09;
   localparam logic [7:0] OP_SUB_IMM = 8'h0A;
   localparam logic [7:0] OP_MOV     = 8'h0B;

   localparam int FLAG_OVF    = 4;
   localparam int FLAG_CARRY  = 3;
   localparam int FLAG_ZERO   = 2;
   localparam int FLAG_SIGN   = 1;
   localparam int FLAG_PARITY = 0;
   localparam int FLAGS_W     = 5;
   localparam int INSTR_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXECUTE,
      ST_WRITEBACK
   } state_t;

   function automatic logic [7:0] instr_opcode(input logic [INSTR_W-1:0] instr);
      return instr[15:8];
   endfunction

   function automatic logic [1:0] instr_rd(input logic [INSTR_W-1:0] instr);
      return instr[7:6];
   endfunction

   function automatic logic [1:0] instr_rs1(input logic [INSTR_W-1:0] instr);
      return instr[5:4];
   endfunction

   function automatic logic [1:0] instr_rs2_idx(input logic [INSTR_W-1:0] instr);
      return instr[1:0];
   endfunction

   function automatic logic [3:0] instr_imm4(input logic [INSTR_W-1:0] instr);
      return instr[3:0];
   endfunction

   function automatic logic op_legal(input logic [7:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_EQ, OP_GT,
         OP_ADD_IMM, OP_SUB_IMM, OP_MOV: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic logic op_uses_imm(input logic [7:0] op);
      return (op == OP_ADD_IMM) || (op == OP_SUB_IMM);
   endfunction

   // Which architectural flags an opcode is allowed to overwrite.
   function automatic logic [FLAGS_W-1:0] flag_mask(input logic [7:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADD_IMM, OP_SUB_IMM: return 5'b11111;
         OP_EQ, OP_GT:                           return 5'b00110;
         default:                                return 5'b00000;
      endcase
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two operand read ports and a debug read port (all
// asynchronous), one synchronous write port, cleared by asynchronous reset.
module alu_regfile #(
   parameter int DATA_W   = 4,
   parameter int NUM_REGS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [1:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [1:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic [1:0]        rd_addr_dbg,
   output logic [DATA_W-1:0] rd_data_dbg
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a   = regs[rd_addr_a];
   assign rd_data_b   = regs[rd_addr_b];
   assign rd_data_dbg = regs[rd_addr_dbg];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer driving a combinational ALU: accepts one instruction
// at a time, reads operands, runs the ALU for one cycle and writes the result back.
module alu_issue_ctrl #(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 4,
   parameter int OPCODE_W = 8
) (
   input  logic                clk_in,
   input  logic                reset_in,
   input  logic                instr_valid_in,
   output logic                instr_ready_out,
   input  logic [15:0]         instr_in,
   output logic                alu_reset_out,
   output logic                alu_enable_out,
   output logic [OPCODE_W-1:0] alu_opcode_out,
   output logic [DATA_W-1:0]   alu_input1_out,
   output logic [DATA_W-1:0]   alu_input2_out,
   input  logic [DATA_W-1:0]   alu_result_in,
   input  logic [4:0]          alu_flags_in,
   output logic                done_out,
   output logic [DATA_W-1:0]   result_out,
   output logic [4:0]          flags_out,
   output logic                illegal_out,
   input  logic [1:0]          reg_rd_addr_in,
   output logic [DATA_W-1:0]   reg_rd_data_out
);
   import alu_pkg::*;

   state_t                state_q, state_nxt;
   logic [INSTR_W-1:0]    instr_q;
   logic [OPCODE_W-1:0]   opcode_q;
   logic [DATA_W-1:0]     op1_q, op2_q, result_q;
   logic [DATA_W-1:0]     rs1_data, rs2_data;
   logic [FLAGS_W-1:0]    flags_cap_q, flags_q, upd_mask;
   logic                  legal_q, illegal_q;
   logic                  wb_en;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) state_q <= ST_IDLE;
      else          state_q <= state_nxt;
   end

   always_comb begin
      state_nxt       = state_q;
      instr_ready_out = 1'b0;
      alu_enable_out  = 1'b0;
      done_out        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            instr_ready_out = 1'b1;
            if (instr_valid_in) state_nxt = ST_DECODE;
         end
         ST_DECODE:  state_nxt = ST_EXECUTE;
         ST_EXECUTE: begin
            alu_enable_out = 1'b1;
            state_nxt      = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            done_out  = 1'b1;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Instruction word is pure data; it is only consumed after a fresh accept.
   always_ff @(posedge clk_in) begin
      if (state_q == ST_IDLE && instr_valid_in) instr_q <= instr_in;
   end

   // Unknown opcodes write nothing, so the mask is forced empty for them.
   assign upd_mask = legal_q ? flag_mask(opcode_q) : '0;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         opcode_q    <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         legal_q     <= 1'b0;
         illegal_q   <= 1'b0;
         result_q    <= '0;
         flags_cap_q <= '0;
         flags_q     <= '0;
      end else begin
         case (state_q)
            ST_DECODE: begin
               opcode_q <= instr_opcode(instr_q);
               op1_q    <= rs1_data;
               op2_q    <= op_uses_imm(instr_opcode(instr_q)) ? DATA_W'(instr_imm4(instr_q)) : rs2_data;
               legal_q  <= op_legal(instr_opcode(instr_q));
               if (!op_legal(instr_opcode(instr_q))) illegal_q <= 1'b1;
            end
            ST_EXECUTE: begin
               result_q    <= legal_q ? alu_result_in : '0;
               flags_cap_q <= alu_flags_in;
            end
            ST_WRITEBACK: flags_q <= (flags_q & ~upd_mask) | (flags_cap_q & upd_mask);
            default: ;
         endcase
      end
   end

   assign wb_en = (state_q == ST_WRITEBACK) && legal_q;

   alu_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk         (clk_in),
      .rst         (reset_in),
      .wr_en       (wb_en),
      .wr_addr     (instr_rd(instr_q)),
      .wr_data     (result_q),
      .rd_addr_a   (instr_rs1(instr_q)),
      .rd_data_a   (rs1_data),
      .rd_addr_b   (instr_rs2_idx(instr_q)),
      .rd_data_b   (rs2_data),
      .rd_addr_dbg (reg_rd_addr_in),
      .rd_data_dbg (reg_rd_data_out)
   );

   assign alu_reset_out  = reset_in;
   assign alu_opcode_out = opcode_q;
   assign alu_input1_out = op1_q;
   assign alu_input2_out = op2_q;
   assign result_out     = result_q;
   assign flags_out      = flags_q;
   assign illegal_out    = illegal_q;

endmodule
